// File: rtl/cdc_gray_ptr_sync.sv
// cdc_gray_ptr_sync: multi-stage Gray pointer synchronizer with binary decode, change pulse and illegal-step detection
module cdc_gray_ptr_sync #(
    parameter int               WIDTH    = 4,
    parameter int               STAGES   = 2,
    parameter logic [WIDTH-1:0] RST_GRAY = '0
) (
    input  logic             s_aclk,
    input  logic             rd_rst,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] sync_gray,
    output logic [WIDTH-1:0] sync_bin,
    output logic             bin_valid,
    output logic             ptr_changed,
    output logic             gray_err,
    output logic             err_sticky
);
    localparam logic [2:0] DONE = 3'(STAGES + 1);

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];
    logic [WIDTH-1:0] prev_q, prev_d, sync_bin_q, sync_bin_d, diff;
    logic [2:0]       cnt_q, cnt_d;
    logic             ptr_changed_q, ptr_changed_d, gray_err_q, gray_err_d, err_sticky_q, err_sticky_d;

    always_comb begin
        stage_d[0] = gray_in;
        for (int k = 1; k < STAGES; k++) stage_d[k] = stage_q[k-1];
        prev_d        = stage_q[STAGES-1];
        sync_bin_d    = gray2bin(stage_q[STAGES-1]);
        cnt_d         = (cnt_q == DONE) ? cnt_q : cnt_q + 3'd1;
        diff          = stage_q[STAGES-1] ^ prev_q;
        // more than one bit set means the source skipped a Gray step
        ptr_changed_d = bin_valid && (diff != '0);
        gray_err_d    = bin_valid && ((diff & (diff - 1'b1)) != '0);
        err_sticky_d  = gray_err_d || (err_sticky_q && !err_clr);
    end

    always_ff @(posedge s_aclk) begin
        if (rd_rst) begin
            stage_q       <= '{default: RST_GRAY};
            prev_q        <= RST_GRAY;
            sync_bin_q    <= gray2bin(RST_GRAY);
            cnt_q         <= '0;
            ptr_changed_q <= 1'b0;
            gray_err_q    <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            stage_q       <= stage_d;
            prev_q        <= prev_d;
            sync_bin_q    <= sync_bin_d;
            cnt_q         <= cnt_d;
            ptr_changed_q <= ptr_changed_d;
            gray_err_q    <= gray_err_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

    assign sync_gray   = stage_q[STAGES-1];
    assign sync_bin    = sync_bin_q;
    assign bin_valid   = (cnt_q == DONE);
    assign ptr_changed = ptr_changed_q;
    assign gray_err    = gray_err_q;
    assign err_sticky  = err_sticky_q;
endmodule

// File: tb/tb_cdc_gray_ptr_sync.sv
// tb_cdc_gray_ptr_sync: two configurations checked every cycle against a sample-history model
module tb_cdc_gray_ptr_sync;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, clr = 1'b0;
    logic [3:0] g4 = '0;
    logic [7:0] g8 = '0;
    logic [3:0] sg4, sb4;
    logic [7:0] sg8, sb8;
    logic       bv4, pc4, ge4, es4, bv8, pc8, ge8, es8;

    cdc_gray_ptr_sync #(.WIDTH(4), .STAGES(2), .RST_GRAY(4'h0)) u4 (
        .s_aclk(clk), .rd_rst(rst), .gray_in(g4), .err_clr(clr), .sync_gray(sg4), .sync_bin(sb4),
        .bin_valid(bv4), .ptr_changed(pc4), .gray_err(ge4), .err_sticky(es4));
    cdc_gray_ptr_sync #(.WIDTH(8), .STAGES(3), .RST_GRAY(8'h80)) u8 (
        .s_aclk(clk), .rd_rst(rst), .gray_in(g8), .err_clr(clr), .sync_gray(sg8), .sync_bin(sb8),
        .bin_valid(bv8), .ptr_changed(pc8), .gray_err(ge8), .err_sticky(es8));

    int tests = 0, fails = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: per configuration, the gray_in value taken at each edge since reset release
    int n [2];
    int hist [2][0:4095];
    bit st [2];

    function automatic int sv(int i); return i ? 3 : 2; endfunction
    function automatic int rv(int i); return i ? 'h80 : 0; endfunction
    function automatic int wv(int i); return i ? 8 : 4; endfunction
    function automatic int gr(int b); return b ^ (b >> 1); endfunction

    function automatic int g2b(int g, int w);
        for (int b = 0; b < (1 << w); b++) if (gr(b) == g) return b;
        return -1;
    endfunction

    function automatic bit warm(int i); return n[i] >= sv(i) + 2; endfunction
    function automatic int dif(int i); return hist[i][n[i]-sv(i)] ^ hist[i][n[i]-sv(i)-1]; endfunction
    function automatic bit e_pc(int i); return warm(i) && dif(i) != 0; endfunction
    function automatic bit e_ge(int i); return warm(i) && $countones(dif(i)) > 1; endfunction
    function automatic bit e_bv(int i); return n[i] >= sv(i) + 1; endfunction
    function automatic logic [15:0] e_sg(int i);
        return 16'(n[i] >= sv(i) ? hist[i][n[i]-sv(i)+1] : rv(i));
    endfunction
    function automatic logic [15:0] e_sb(int i);
        return 16'(g2b(e_bv(i) ? hist[i][n[i]-sv(i)] : rv(i), wv(i)));
    endfunction

    task automatic model(input int i, input int g);
        if (rst) begin
            n[i] = 0;
            st[i] = 0;
        end else begin
            if (n[i] < 4095) n[i]++;
            hist[i][n[i]] = g;
            st[i] = e_ge(i) || (st[i] && !clr);
        end
    endtask

    task automatic cmp(input int i, input logic [15:0] sg, input logic [15:0] sb, input logic bv,
                       input logic pc, input logic ge, input logic es);
        string p;
        p = $sformatf("w%0d_", wv(i));
        check({p, "sync_gray"}, sg, e_sg(i));
        check({p, "sync_bin"}, sb, e_sb(i));
        check({p, "bin_valid"}, 16'(bv), 16'(e_bv(i)));
        check({p, "ptr_changed"}, 16'(pc), 16'(e_pc(i)));
        check({p, "gray_err"}, 16'(ge), 16'(e_ge(i)));
        check({p, "err_sticky"}, 16'(es), 16'(st[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        model(0, int'(g4));
        model(1, int'(g8));
        #1;
        cmp(0, 16'(sg4), 16'(sb4), bv4, pc4, ge4, es4);
        cmp(1, 16'(sg8), 16'(sb8), bv8, pc8, ge8, es8);
    endtask

    task automatic setg(input int b);
        g4 = 4'(gr(b));
        g8 = 8'(gr(b));
    endtask

    int b4 = 0, b8 = 0, op;

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        setg(0);
        repeat (5) tick();
        for (int b = 1; b <= 3; b++) begin
            setg(b);
            tick();
        end
        repeat (5) tick();
        g4 = 4'b1000;
        g8 = 8'h80;
        repeat (4) tick();
        setg(0);
        repeat (5) tick();
        g4 = 4'b0011;
        g8 = 8'h03;
        tick();
        tick();
        clr = 1'b1;
        tick();
        check("coincide_gray_err", 16'(ge4), 16'd1);
        check("coincide_sticky", 16'(es4), 16'd1);
        clr = 1'b0;
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("sticky_cleared", 16'(es4), 16'd0);
        repeat (2) tick();
        setg(4);
        tick();
        setg(5);
        tick();
        rst = 1'b1;
        tick();
        check("midreset_valid4", 16'(bv4), 16'd0);
        check("midreset_valid8", 16'(bv8), 16'd0);
        rst = 1'b0;
        repeat (6) tick();
        repeat (400) begin
            op = int'($urandom_range(0, 9));
            if (op <= 3) begin b4++; b8++; end
            else if (op <= 5) begin b4--; b8--; end
            else if (op == 8) begin b4 = int'($urandom); b8 = int'($urandom); end
            b4 &= 15;
            b8 &= 255;
            g4 = 4'(gr(b4));
            g8 = 8'(gr(b8));
            clr = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 79) == 0);
            tick();
        end
        rst = 1'b0;
        clr = 1'b0;
        repeat (6) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdc_gray_ptr_sync.md
CDC_GRAY_PTR_SYNC -- requirements
Module: cdc_gray_ptr_sync

Interface
REQ-001 Parameter WIDTH, default 4: pointer width in bits; legal range 2..16.
REQ-002 Parameter STAGES, default 2: synchronizer flop stages; legal range 2..4.
REQ-003 Parameter RST_GRAY, default 0: reset value of every synchronizer stage and of the previous-value register, given as a Gray code.
REQ-004 s_aclk  input  1  destination-domain clock; all flops clock on its rising edge.
REQ-005 rd_rst  input  1  synchronous, active-high reset, sampled on the s_aclk rising edge.
REQ-006 gray_in  input  WIDTH  Gray-coded pointer from the source domain; asynchronous to s_aclk.
REQ-007 err_clr  input  1  clears err_sticky.
REQ-008 sync_gray  output  WIDTH  final synchronizer stage.
REQ-009 sync_bin  output  WIDTH  registered binary decode of sync_gray.
REQ-010 bin_valid  output  1  high once the pipeline holds post-reset samples.
REQ-011 ptr_changed  output  1  one-cycle pulse: the decoded pointer moved.
REQ-012 gray_err  output  1  one-cycle pulse: an illegal multi-bit Gray step was sampled.
REQ-013 err_sticky  output  1  latched gray_err.

Function
REQ-014 The block SHALL chain STAGES registers, stage[0] <= gray_in and stage[k] <= stage[k-1]; sync_gray = stage[STAGES-1].
REQ-015 Latency from gray_in to sync_gray SHALL be exactly STAGES cycles; there is no combinational path from gray_in to any output.
REQ-016 The block SHALL hold prev <= sync_gray every cycle.
REQ-017 sync_bin SHALL be registered as gray2bin(sync_gray): bin[W-1] = g[W-1], bin[i] = bin[i+1] XOR g[i]; latency from gray_in is STAGES+1.
REQ-018 ptr_changed SHALL be registered as (sync_gray != prev) AND warm-up done, aligned with the sync_bin update.
REQ-019 gray_err SHALL be registered as (popcount(sync_gray XOR prev) > 1) AND warm-up done, in the same cycle as ptr_changed.
REQ-020 err_sticky SHALL set on gray_err and clear on err_clr; when both occur in the same cycle, the set wins.
REQ-021 A warm-up counter SHALL count from 0 to STAGES+1 after rd_rst deasserts, then saturate; bin_valid = (count == STAGES+1).
REQ-022 The warm-up SHALL be complete when bin_valid is high; ptr_changed and gray_err are forced low before then.
REQ-023 Wrap-around (for example 1000 -> 0000 at WIDTH=4) is a single-bit step: ptr_changed=1, gray_err=0, sync_bin 15 -> 0.
REQ-024 A held gray_in SHALL produce no ptr_changed pulse after the first STAGES+1 cycles.
REQ-025 Consecutive single-bit steps on every cycle SHALL each produce a ptr_changed pulse, with no gray_err.

Reset
REQ-026 When rd_rst=1 at an edge, the following SHALL take their reset values: stages and prev = RST_GRAY; sync_bin = gray2bin(RST_GRAY); bin_valid, ptr_changed, gray_err, err_sticky and counter = 0.
REQ-027 rd_rst SHALL take priority over err_clr and over every data update.
REQ-028 Reset asserted mid-operation SHALL take effect at the next edge, discard all in-flight samples and restart warm-up.

Verification
REQ-029 WIDTH=4, STAGES=2: release reset with gray_in=0000 -> bin_valid rises on the 3rd edge after release; sync_bin=0; no pulses.
REQ-030 After warm-up, step gray_in 0000->0001->0011->0010, one step per cycle -> sync_bin shows 1, 2, 3 on consecutive cycles, each 3 cycles after its input; three ptr_changed pulses; gray_err=0.
REQ-031 Set gray_in=1000 (bin 15), then 0000 -> sync_bin 15 then 0; ptr_changed pulse; gray_err=0.
REQ-032 Jump gray_in 0000->0011 in one cycle -> gray_err pulse and err_sticky=1, both 3 cycles later; err_sticky stays 1 when gray_err and err_clr coincide; it clears on a later err_clr.
REQ-033 Assert rd_rst while steps are in flight -> next cycle all outputs are at reset values and bin_valid=0; bin_valid re-asserts 3 cycles after release.
REQ-034 Repeat REQ-029 and REQ-030 with WIDTH=8, STAGES=3 and RST_GRAY=8'h80 -> latency 4; reset value of sync_bin = 8'hFF.
